// File: rtl/instr_realign.sv
// ---------------------------------------------------------------------------
// instr_realign
//
// Splits 32-bit fetch words into individual RISC-V instructions (16-bit
// compressed or 32-bit) and pushes at most one instruction per cycle into the
// downstream instruction FIFO. A 32-bit instruction that straddles two fetch
// words is stitched together from a held halfword, and halfword-aligned
// branch targets (fetch_addr_i[1]=1) skip the lower halfword of the word.
//
// State  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no halfword held; next fetch word may start anywhere
// UNALGN | P holds the first half of a 32-bit instruction at PA; the next
//        | word must be sequential and supplies its second half
// UPPERC | P holds a complete compressed instruction at PA; it is pushed
//        | before any further fetch word is accepted
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   flush_i            synchronous redirect/kill, drops any held halfword
//   fetch_valid_i      fetch word valid
//   fetch_ready_o      word consumed when fetch_valid_i && fetch_ready_o
//   fetch_data_i       32-bit fetch word, little-endian halfwords
//   fetch_addr_i       address of first useful halfword
//   full_i             downstream FIFO full
//   push_o             push one instruction (never while full_i=1)
//   instr_o            instruction; compressed ones zero-extended
//   addr_o             instruction address
//   compressed_o       instr_o carries a 16-bit instruction
// ---------------------------------------------------------------------------
module instr_realign #(
    parameter int ADDR_WIDTH = 64,
    parameter int ENABLE_C   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fetch_valid_i,
    output logic                  fetch_ready_o,
    input  logic [31:0]           fetch_data_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    input  logic                  full_i,
    output logic                  push_o,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  compressed_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] UNALIGNED = 2'd1;
    localparam logic [1:0] UPPER_C   = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] HW_STEP   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    logic [1:0]            state_q, state_d;
    logic [15:0]           p_q, p_d;
    logic [ADDR_WIDTH-1:0] pa_q, pa_d;

    logic [15:0] lo_hw;
    logic [15:0] hi_hw;
    logic        lo_is_c;
    logic        hi_is_c;
    logic        ready;
    logic        consume;

    assign lo_hw   = fetch_data_i[15:0];
    assign hi_hw   = fetch_data_i[31:16];
    assign lo_is_c = (lo_hw[1:0] != 2'b11);
    assign hi_is_c = (hi_hw[1:0] != 2'b11);

    // While a complete compressed instruction is held, the word port stalls
    // so that only one instruction per cycle ever leaves the block.
    assign ready   = ~rst_i & ~flush_i & ~full_i & (state_q != UPPER_C);
    assign consume = fetch_valid_i & ready;

    assign fetch_ready_o = ready;

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        pa_d         = pa_q;
        push_o       = 1'b0;
        instr_o      = 32'h0;
        addr_o       = '0;
        compressed_o = 1'b0;

        if (ENABLE_C == 0) begin
            state_d = IDLE;
            if (consume) begin
                push_o  = 1'b1;
                instr_o = fetch_data_i;
                addr_o  = fetch_addr_i;
            end
        end else if (flush_i) begin
            state_d = IDLE;
            p_d     = 16'h0;
            pa_d    = '0;
        end else if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (consume) begin
                        if (!fetch_addr_i[1]) begin
                            if (!lo_is_c) begin
                                push_o  = 1'b1;
                                instr_o = fetch_data_i;
                                addr_o  = fetch_addr_i;
                            end else begin
                                push_o       = 1'b1;
                                instr_o      = {16'h0, lo_hw};
                                addr_o       = fetch_addr_i;
                                compressed_o = 1'b1;
                                p_d          = hi_hw;
                                pa_d         = fetch_addr_i + HW_STEP;
                                state_d      = hi_is_c ? UPPER_C : UNALIGNED;
                            end
                        end else begin
                            // Halfword-aligned target: the lower half is not
                            // part of the instruction stream.
                            if (hi_is_c) begin
                                push_o       = 1'b1;
                                instr_o      = {16'h0, hi_hw};
                                addr_o       = fetch_addr_i;
                                compressed_o = 1'b1;
                            end else begin
                                p_d     = hi_hw;
                                pa_d    = fetch_addr_i;
                                state_d = UNALIGNED;
                            end
                        end
                    end
                end

                UNALIGNED: begin
                    if (consume) begin
                        push_o  = 1'b1;
                        instr_o = {lo_hw, p_q};
                        addr_o  = pa_q;
                        p_d     = hi_hw;
                        pa_d    = pa_q + WORD_STEP;
                        state_d = hi_is_c ? UPPER_C : UNALIGNED;
                    end
                end

                UPPER_C: begin
                    if (!full_i) begin
                        push_o       = 1'b1;
                        instr_o      = {16'h0, p_q};
                        addr_o       = pa_q;
                        compressed_o = 1'b1;
                        state_d      = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            p_q     <= 16'h0;
            pa_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            pa_q    <= pa_d;
        end
    end

`ifndef SYNTHESIS
    // Fetch protocol checks: the word following a held first half must be
    // the next sequential word, and with RVC disabled every word is aligned.
    always @(posedge clk_i) begin
        if (!rst_i && fetch_valid_i && fetch_ready_o) begin
            if (ENABLE_C != 0 && state_q == UNALIGNED) begin
                assert (fetch_addr_i[1] == 1'b0 && fetch_addr_i == pa_q + HW_STEP)
                else $error("instr_realign: non-sequential word while a halfword is pending");
            end
            if (ENABLE_C == 0) begin
                assert (fetch_addr_i[1] == 1'b0)
                else $error("instr_realign: halfword-aligned address with RVC disabled");
            end
        end
        if (!rst_i && push_o) begin
            assert (!full_i)
            else $error("instr_realign: push while downstream full");
        end
    end
`endif

endmodule
